goose_hit_detect: RTL and testbench
===================================

# goose_hit_detect

Per-frame collision judge and score keeper for the goose-run game. Sits directly downstream of the goose sprite renderer and the obstacle renderer. Watches their per-pixel coverage flags during scan-out and declares a hit at frame end when enough pixels overlap. Drives the `check_hit` level that freezes the goose, and keeps a 4-digit BCD score that advances while the game runs.

## Interface
Parameters:
- `H_ACTIVE`, 640: visible pixels per line; `x >= H_ACTIVE` is ignored.
- `V_ACTIVE`, 480: visible lines; `y >= V_ACTIVE` is ignored.
- `HIT_THRESHOLD`, 4: overlapping pixels in one frame needed to declare a hit (1..255).
- `SCORE_DIV`, 6: running frames per score increment (1..255).

Ports:
- `clk` in 1: system clock.
- `reset` in 1: asynchronous, active-high.
- `pixel_tick` in 1: one-cycle strobe; `x`, `y`, `goose` and `obstacle` are valid only in this cycle.
- `frame_tick` in 1: one-cycle strobe at start of vertical blanking (end of frame).
- `x`, `y` in 10 each: current pixel coordinate.
- `goose` in 1: goose sprite covers the current pixel.
- `obstacle` in 1: obstacle covers the current pixel.
- `check_hit` out 1: level; 1 from hit declaration until reset.
- `score` out 16: 4 BCD digits, `score[15:12]` is thousands.
- `hit_x`, `hit_y` out 10 each: coordinate of the first overlap pixel in the frame that caused the hit.

## Operation
- State machine with three states:
  - IDLE: entered on reset. Overlap pixels are not counted. The first `frame_tick` moves to RUN; that tick scores nothing.
  - RUN: counts overlap pixels and advances the score at each frame end.
  - HIT: terminal; only `reset` exits.
- A qualifying pixel in RUN needs all of: `pixel_tick`, `goose`, `obstacle`, `x < H_ACTIVE`, `y < V_ACTIVE`, and no `frame_tick` in the same cycle.
- Overlap counter: 8 bits, saturates at `HIT_THRESHOLD`, cleared on every `frame_tick`.
- First-overlap capture: the first qualifying pixel of a frame latches its `x`, `y` into internal candidate registers. Later overlaps in the same frame do not overwrite them.
- `frame_tick` in RUN, when overlap count >= `HIT_THRESHOLD`:
  - go to HIT;
  - set `check_hit`;
  - copy the candidates to `hit_x`, `hit_y`;
  - the score is not incremented for this frame.
- `frame_tick` in RUN, otherwise:
  - the frame counter increments;
  - at `SCORE_DIV-1` it wraps to 0 and `score` increments by 1 in BCD, with a digit carry at 9;
  - at 9999 the score saturates and the frame counter keeps wrapping.
- HIT: `score`, `hit_x`, `hit_y` and `check_hit` are frozen. All ticks are ignored.
- `frame_tick` has priority: an overlap pixel coincident with `frame_tick` is discarded and counts toward neither frame.

## Timing
- Reset values: `check_hit`=0, `score`=16'h0000, `hit_x`=0, `hit_y`=0. Internal counters and candidates are 0; state is IDLE.
- All outputs are registered. No combinational path from inputs to outputs.
- Latency:
  - `check_hit`, `hit_x`, `hit_y` update on the first rising edge after the `frame_tick` cycle (1 cycle).
  - `score` updates on the same edge.
- Overlap count reflects pixels through the previous edge.
- `reset` asserted mid-frame or in HIT:
  - outputs clear immediately, without waiting for a clock;
  - after release the block is in IDLE and waits for the next `frame_tick` before counting.
- Back-to-back `frame_tick` on consecutive cycles is legal. Each tick closes an (empty) frame.
- `pixel_tick` with no `frame_tick` for any number of cycles never overflows the counter, because it saturates.

## Test plan
- Reset, one `frame_tick` (IDLE to RUN), then 12 frames with no overlap and `SCORE_DIV`=6 -> `score`=16'h0002, `check_hit`=0 throughout.
- Frame with exactly 3 overlap pixels at `HIT_THRESHOLD`=4 -> no hit, and the counter clears. Next frame with 4 overlaps, the first at (120,380) -> `check_hit`=1 one cycle after `frame_tick`, `hit_x`=120, `hit_y`=380, `score` unchanged.
- In HIT, 10 more frames with overlaps and different coordinates -> `score`, `hit_x`, `hit_y` unchanged and `check_hit` stays 1. Assert `reset` -> all outputs 0 without a clock edge.
- Preload `score` to 9999 by running frames, then run 6 more frames -> `score` stays 16'h9999. Separately, 16'h0099 plus one increment -> 16'h0100.
- Overlap pixels at x=640 and at y=480 only, 20 per frame -> never a hit. Four overlap pixels each coincident with `frame_tick` -> no hit.
- `reset` pulse mid-frame after 3 overlaps -> after release, no counting until the first `frame_tick`. A following frame with 3 overlaps gives no hit, confirming the count restarted at 0.

Source files
------------

// File: rtl/goose_hit_detect_if.sv
// Pixel/frame strobes from the renderers and the collision/score results
// returned to the game logic.
interface goose_hit_detect_if;
  logic        pixel_tick;
  logic        frame_tick;
  logic [9:0]  x;
  logic [9:0]  y;
  logic        goose;
  logic        obstacle;
  logic        check_hit;
  logic [15:0] score;
  logic [9:0]  hit_x;
  logic [9:0]  hit_y;

  modport master (
    output pixel_tick, frame_tick, x, y, goose, obstacle,
    input  check_hit, score, hit_x, hit_y
  );

  modport slave (
    input  pixel_tick, frame_tick, x, y, goose, obstacle,
    output check_hit, score, hit_x, hit_y
  );
endinterface

// File: rtl/goose_hit_detect.sv
// Per-frame goose/obstacle collision judge with a 4-digit BCD score.
// Overlap pixels are counted during RUN; at frame end either a hit is
// declared (terminal until reset) or the frame counts toward the score.
module goose_hit_detect #(
  parameter int H_ACTIVE      = 640,
  parameter int V_ACTIVE      = 480,
  parameter int HIT_THRESHOLD = 4,
  parameter int SCORE_DIV     = 6
) (
  input  logic              clk,
  input  logic              reset,
  goose_hit_detect_if.slave bus
);

  localparam logic [10:0] H_LIM    = 11'(H_ACTIVE);
  localparam logic [10:0] V_LIM    = 11'(V_ACTIVE);
  localparam logic [7:0]  THRESH   = 8'(HIT_THRESHOLD);
  localparam logic [7:0]  DIV_LAST = 8'(SCORE_DIV - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HIT  = 2'd2
  } state_t;

  state_t      state;
  logic [7:0]  ovl_cnt;
  logic [7:0]  frame_cnt;
  logic [9:0]  cand_x;
  logic [9:0]  cand_y;
  logic [9:0]  hit_x_r;
  logic [9:0]  hit_y_r;
  logic [15:0] score_r;
  logic        check_hit_r;
  logic        qual;

  // BCD +1 with ripple carry between digits; 9999 holds.
  function automatic logic [15:0] bcd_inc(input logic [15:0] v);
    logic [15:0] r;
    logic        carry;
    r     = v;
    carry = 1'b1;
    if (v != 16'h9999) begin
      for (int i = 0; i < 4; i++) begin
        if (carry) begin
          if (r[i*4 +: 4] == 4'd9) begin
            r[i*4 +: 4] = 4'd0;
          end else begin
            r[i*4 +: 4] = r[i*4 +: 4] + 4'd1;
            carry       = 1'b0;
          end
        end
      end
    end
    return r;
  endfunction

  // A pixel counts only when both sprites cover it inside the visible area;
  // a coincident frame_tick wins and the pixel is dropped.
  always_comb begin
    qual = bus.pixel_tick & bus.goose & bus.obstacle &
           ({1'b0, bus.x} < H_LIM) & ({1'b0, bus.y} < V_LIM) &
           ~bus.frame_tick;
  end

  // Game state, overlap counting, first-overlap capture and scoring.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      ovl_cnt     <= 8'd0;
      frame_cnt   <= 8'd0;
      cand_x      <= 10'd0;
      cand_y      <= 10'd0;
      hit_x_r     <= 10'd0;
      hit_y_r     <= 10'd0;
      score_r     <= 16'h0000;
      check_hit_r <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.frame_tick) state <= RUN;
        end
        RUN: begin
          if (bus.frame_tick) begin
            ovl_cnt <= 8'd0;
            if (ovl_cnt >= THRESH) begin
              state       <= HIT;
              check_hit_r <= 1'b1;
              hit_x_r     <= cand_x;
              hit_y_r     <= cand_y;
            end else if (frame_cnt == DIV_LAST) begin
              frame_cnt <= 8'd0;
              score_r   <= bcd_inc(score_r);
            end else begin
              frame_cnt <= frame_cnt + 8'd1;
            end
          end else if (qual) begin
            // Count is zero only before the first overlap of the frame.
            if (ovl_cnt == 8'd0) begin
              cand_x <= bus.x;
              cand_y <= bus.y;
            end
            if (ovl_cnt < THRESH) ovl_cnt <= ovl_cnt + 8'd1;
          end
        end
        HIT: begin
          state <= HIT;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.check_hit = check_hit_r;
  assign bus.score     = score_r;
  assign bus.hit_x     = hit_x_r;
  assign bus.hit_y     = hit_y_r;

endmodule

// File: tb/tb_goose_hit_detect.sv
// Bench for goose_hit_detect: directed and random frames, a scoreboard of
// expected results per frame_tick, and a second instance for score carry.
module tb_goose_hit_detect;

  localparam int TH  = 4;
  localparam int DIV = 6;

  logic clk = 1'b0;
  logic reset;
  logic reset2;
  always #5 clk = ~clk;

  goose_hit_detect_if ifc ();
  goose_hit_detect_if ifc2 ();

  goose_hit_detect #(.H_ACTIVE(640), .V_ACTIVE(480), .HIT_THRESHOLD(TH), .SCORE_DIV(DIV))
    dut (.clk(clk), .reset(reset), .bus(ifc));

  goose_hit_detect #(.H_ACTIVE(640), .V_ACTIVE(480), .HIT_THRESHOLD(TH), .SCORE_DIV(1))
    dut2 (.clk(clk), .reset(reset2), .bus(ifc2));

  typedef struct {
    logic        ch;
    logic [15:0] sc;
    logic [9:0]  hx;
    logic [9:0]  hy;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;

  int n_total = 0;
  int n_pass  = 0;
  bit done2   = 0;

  // reference model state: 0 idle, 1 running, 2 hit
  int         m_st, m_ovl, m_frames, m_score;
  logic       m_hit;
  logic [9:0] m_hx, m_hy, m_fx, m_fy;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] req);
    n_total++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %h required %h", name, act, req);
  endtask

  function automatic logic [15:0] to_bcd(input int s);
    return {4'(s / 1000), 4'((s / 100) % 10), 4'((s / 10) % 10), 4'(s % 10)};
  endfunction

  task automatic model_clear();
    m_st = 0; m_ovl = 0; m_frames = 0; m_score = 0;
    m_hit = 0; m_hx = 0; m_hy = 0; m_fx = 0; m_fy = 0;
  endtask

  // One clock of stimulus; the model follows the game rules directly.
  task automatic drive(input logic pt, input logic ft, input logic [9:0] px,
                       input logic [9:0] py, input logic g, input logic o);
    exp_t e;
    @(posedge clk); #1;
    ifc.pixel_tick = pt; ifc.frame_tick = ft; ifc.x = px; ifc.y = py;
    ifc.goose = g; ifc.obstacle = o;
    if (m_st == 0) begin
      if (ft) m_st = 1;
    end else if (m_st == 1) begin
      if (ft) begin
        if (m_ovl >= TH) begin
          m_st = 2; m_hit = 1; m_hx = m_fx; m_hy = m_fy;
        end else begin
          m_frames++;
          if (m_frames % DIV == 0 && m_score < 9999) m_score++;
        end
        m_ovl = 0;
      end else if (pt && g && o && px < 640 && py < 480) begin
        if (m_ovl == 0) begin m_fx = px; m_fy = py; end
        m_ovl++;
      end
    end
    if (ft) begin
      e.ch = m_hit; e.sc = to_bcd(m_score); e.hx = m_hx; e.hy = m_hy;
      exp_q.push_back(e);
    end
  endtask

  task automatic frame_end();
    drive(1'b0, 1'b1, 10'd0, 10'd0, 1'b0, 1'b0);
  endtask

  task automatic overlap(input logic [9:0] px, input logic [9:0] py);
    drive(1'b1, 1'b0, px, py, 1'b1, 1'b1);
  endtask

  task automatic clean_frame(input int npix);
    logic g;
    for (int i = 0; i < npix; i++) begin
      g = 1'($urandom % 2);
      drive(1'b1, 1'b0, 10'($urandom % 640), 10'($urandom % 480), g, !g);
    end
    frame_end();
  endtask

  task automatic overlap_frame(input int n, input logic [9:0] fx, input logic [9:0] fy);
    overlap(fx, fy);
    for (int i = 1; i < n; i++) overlap(10'($urandom % 640), 10'($urandom % 480));
    frame_end();
  endtask

  task automatic rand_frame(input int npix);
    for (int i = 0; i < npix; i++)
      drive(1'($urandom % 4 != 0), 1'b0, 10'($urandom % 700), 10'($urandom % 520),
            1'($urandom % 2 == 0), 1'($urandom % 2 == 0));
    drive(1'($urandom % 2), 1'b1, 10'($urandom % 640), 10'($urandom % 480),
          1'($urandom % 2), 1'($urandom % 2));
  endtask

  // Reset asserted away from any clock edge; outputs must clear at once.
  task automatic do_reset(input string tag);
    drive(1'b0, 1'b0, 10'd0, 10'd0, 1'b0, 1'b0);
    @(negedge clk); #1;
    reset = 1'b1;
    #1;
    check({tag, "_check_hit"}, 16'(ifc.check_hit), 16'h0);
    check({tag, "_score"}, ifc.score, 16'h0000);
    check({tag, "_hit_x"}, 16'(ifc.hit_x), 16'h0);
    check({tag, "_hit_y"}, 16'(ifc.hit_y), 16'h0);
    model_clear();
    exp_q.delete();
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  // Scoreboard monitor: results appear one edge after each frame_tick.
  always @(posedge clk) begin
    if (!reset && ifc.frame_tick) begin
      @(negedge clk);
      if (exp_q.size() == 0) begin
        n_total++;
        $display("FAIL scoreboard: frame_tick with no expected entry");
      end else begin
        mon_e = exp_q.pop_front();
        check("check_hit", 16'(ifc.check_hit), 16'(mon_e.ch));
        check("score", ifc.score, mon_e.sc);
        check("hit_x", 16'(ifc.hit_x), 16'(mon_e.hx));
        check("hit_y", 16'(ifc.hit_y), 16'(mon_e.hy));
      end
    end
  end

  task automatic run2(input int k);
    @(posedge clk); #1;
    ifc2.frame_tick = 1'b1;
    repeat (k) @(posedge clk);
    #1;
    ifc2.frame_tick = 1'b0;
    @(negedge clk);
  endtask

  // Score carry and saturation on an instance that scores every frame.
  initial begin
    ifc2.pixel_tick = 0; ifc2.frame_tick = 0; ifc2.x = 0; ifc2.y = 0;
    ifc2.goose = 0; ifc2.obstacle = 0;
    reset2 = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset2 = 1'b0;
    run2(1);
    check("s2_idle_tick", ifc2.score, 16'h0000);
    run2(99);
    check("s2_0099", ifc2.score, 16'h0099);
    run2(1);
    check("s2_0100", ifc2.score, 16'h0100);
    run2(899);
    check("s2_0999", ifc2.score, 16'h0999);
    run2(1);
    check("s2_1000", ifc2.score, 16'h1000);
    run2(8999);
    check("s2_9999", ifc2.score, 16'h9999);
    run2(6);
    check("s2_sat", ifc2.score, 16'h9999);
    check("s2_no_hit", 16'(ifc2.check_hit), 16'h0);
    done2 = 1;
  end

  initial begin
    ifc.pixel_tick = 0; ifc.frame_tick = 0; ifc.x = 0; ifc.y = 0;
    ifc.goose = 0; ifc.obstacle = 0;
    model_clear();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_check_hit", 16'(ifc.check_hit), 16'h0);
    check("rst_score", ifc.score, 16'h0000);
    check("rst_hit_x", 16'(ifc.hit_x), 16'h0);
    check("rst_hit_y", 16'(ifc.hit_y), 16'h0);
    @(posedge clk); #1 reset = 1'b0;

    // IDLE -> RUN, then 12 clean frames
    frame_end();
    for (int f = 0; f < 12; f++) clean_frame(5);

    // 3 overlaps: no hit; then 4 overlaps starting at (120,380): hit
    overlap_frame(3, 10'd200, 10'd100);
    overlap_frame(4, 10'd120, 10'd380);

    // frozen in HIT
    for (int f = 0; f < 10; f++) overlap_frame(5, 10'($urandom % 640), 10'($urandom % 480));
    do_reset("rst_hit");

    // out-of-range overlaps and overlaps coincident with frame_tick
    frame_end();
    for (int f = 0; f < 3; f++) begin
      for (int i = 0; i < 10; i++) overlap(10'd640, 10'($urandom % 480));
      for (int i = 0; i < 10; i++) overlap(10'($urandom % 640), 10'd480);
      frame_end();
    end
    for (int i = 0; i < 4; i++) drive(1'b1, 1'b1, 10'd50, 10'd60, 1'b1, 1'b1);
    frame_end();

    // mid-frame reset after 3 overlaps; IDLE overlaps must not count
    overlap(10'd10, 10'd10); overlap(10'd11, 10'd10); overlap(10'd12, 10'd10);
    do_reset("rst_mid");
    for (int i = 0; i < 3; i++) overlap(10'd30, 10'd30);
    frame_end();
    overlap_frame(3, 10'd40, 10'd41);

    // random frames across several games
    for (int g = 0; g < 4; g++) begin
      do_reset("rst_rand");
      frame_end();
      for (int f = 0; f < 25; f++) rand_frame(int'($urandom % 12));
    end

    repeat (3) drive(1'b0, 1'b0, 10'd0, 10'd0, 1'b0, 1'b0);
    check("queue_drained", 16'(exp_q.size()), 16'h0);

    for (int i = 0; i < 30000 && !done2; i++) @(posedge clk);
    if (!done2) begin
      n_total++;
      $display("FAIL timeout: score instance done=%0d required 1", done2);
    end
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
